multicycle_main_control: RTL and testbench

//  Control FSM for the multicycle RISC-V core with cache. Sequences fetch, decode, execute, memory and writeback.

---
 rtl/riscv_ctrl_pkg.sv | 66 ++++++
 rtl/imm_src_decoder.sv | 31 +++
 rtl/multicycle_main_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_ctrl_pkg
// Description : Shared encodings for the multicycle RISC-V control path:
//               opcodes, main-FSM state codes and the datapath select codes
//               (ALUOp, ALUSrcA/B, ResultSrc, ImmSrc) also used by the
//               ALU decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_r    = 7'b0110011;
  localparam logic [6:0] c_op_i    = 7'b0010011;
  localparam logic [6:0] c_op_beq  = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;

  // Main FSM state encodings (11 of 16 codes used)
  localparam logic [3:0] c_s_fetch    = 4'd0;
  localparam logic [3:0] c_s_decode   = 4'd1;
  localparam logic [3:0] c_s_memadr   = 4'd2;
  localparam logic [3:0] c_s_memread  = 4'd3;
  localparam logic [3:0] c_s_memwb    = 4'd4;
  localparam logic [3:0] c_s_memwrite = 4'd5;
  localparam logic [3:0] c_s_execr    = 4'd6;
  localparam logic [3:0] c_s_execi    = 4'd7;
  localparam logic [3:0] c_s_aluwb    = 4'd8;
  localparam logic [3:0] c_s_beq      = 4'd9;
  localparam logic [3:0] c_s_jal      = 4'd10;

  // ALUOp codes (consumed by the ALU decoder)
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  // ALU operand A select
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_rd1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] c_srcb_rd2  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  // Result mux select
  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_readdata  = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  // Immediate format select
  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  // True for every opcode the control FSM knows how to sequence.
  function automatic logic is_supported_op(input logic [6:0] op);
    return (op == c_op_lw) || (op == c_op_sw) || (op == c_op_r) ||
           (op == c_op_i)  || (op == c_op_beq) || (op == c_op_jal);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_src_decoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_src_decoder
// Description : Combinational opcode -> immediate format select. Valid in
//               every FSM state so the extender output is always ready.
// Ports       : i_op      - Instr[6:0]
//               o_imm_src - 00=I, 01=S, 10=B, 11=J
// Revision    : 1.0 - initial release
// ============================================================================
module imm_src_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W = 7
) (
  input  logic [OP_W-1:0] i_op,
  output logic [1:0]      o_imm_src
);

  always_comb begin
    o_imm_src = c_imm_i;
    case (i_op)
      c_op_sw:  o_imm_src = c_imm_s;
      c_op_beq: o_imm_src = c_imm_b;
      c_op_jal: o_imm_src = c_imm_j;
      // lw, op-imm, R-type and unknown opcodes use the I format
      default:  o_imm_src = c_imm_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_control
// Description : Main control FSM of the multicycle RISC-V core. Sequences
//               fetch/decode/execute/memory/writeback and handshakes with
//               the write-through cache (MemReq held until MemReady).
// Ports       : CLK, RST (async, active-low)
//               Op, Zero, MemReady           - inputs
//               MemReq, MemWrite, AdrSrc      - memory interface
//               IRWrite, PCWrite, RegWrite    - register enables
//               ALUSrcA, ALUSrcB, ALUOp       - ALU controls
//               ResultSrc, ImmSrc             - datapath selects
//               IllegalInstr                  - unsupported opcode pulse
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            MemReady,
  output logic            MemReq,
  output logic            MemWrite,
  output logic            AdrSrc,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ImmSrc,
  output logic            IllegalInstr
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;

  logic w_mem_req;
  logic w_mem_write;
  logic w_ir_write;
  logic w_pc_update;
  logic w_branch;
  logic w_reg_write;
  logic w_illegal;

  // --------------------------------------------------------------------------
  // State register. Asserting reset mid-access abandons the cache request;
  // the PC was not advanced, so FETCH restarts at the current PC.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_s_fetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = c_s_fetch;
    case (r_state)
      c_s_fetch:    w_next_state = MemReady ? c_s_decode : c_s_fetch;
      c_s_decode: begin
        case (Op)
          c_op_lw,
          c_op_sw:  w_next_state = c_s_memadr;
          c_op_r:   w_next_state = c_s_execr;
          c_op_i:   w_next_state = c_s_execi;
          c_op_beq: w_next_state = c_s_beq;
          c_op_jal: w_next_state = c_s_jal;
          default:  w_next_state = c_s_fetch;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything other than sw is a load.
      c_s_memadr:   w_next_state = (Op == c_op_sw) ? c_s_memwrite : c_s_memread;
      c_s_memread:  w_next_state = MemReady ? c_s_memwb : c_s_memread;
      c_s_memwb:    w_next_state = c_s_fetch;
      c_s_memwrite: w_next_state = MemReady ? c_s_fetch : c_s_memwrite;
      c_s_execr:    w_next_state = c_s_aluwb;
      c_s_execi:    w_next_state = c_s_aluwb;
      c_s_aluwb:    w_next_state = c_s_fetch;
      c_s_beq:      w_next_state = c_s_fetch;
      // rd = PC+4 is computed here and written back via ALUWB
      c_s_jal:      w_next_state = c_s_aluwb;
      default:      w_next_state = c_s_fetch;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore, except IRWrite/PCUpdate gated by MemReady in FETCH)
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    AdrSrc      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    ALUSrcA     = c_srca_pc;
    ALUSrcB     = c_srcb_rd2;
    ALUOp       = c_aluop_add;
    ResultSrc   = c_res_aluout;
    case (r_state)
      c_s_fetch: begin
        w_mem_req   = 1'b1;
        ALUSrcA     = c_srca_pc;
        ALUSrcB     = c_srcb_four;
        ALUOp       = c_aluop_add;
        ResultSrc   = c_res_aluresult;
        w_ir_write  = MemReady;
        w_pc_update = MemReady;
      end
      c_s_decode: begin
        // Speculative branch target OldPC + imm
        ALUSrcA   = c_srca_oldpc;
        ALUSrcB   = c_srcb_imm;
        ALUOp     = c_aluop_add;
        w_illegal = !is_supported_op(Op);
      end
      c_s_memadr: begin
        ALUSrcA = c_srca_rd1;
        ALUSrcB = c_srcb_imm;
        ALUOp   = c_aluop_add;
      end
      c_s_memread: begin
        w_mem_req = 1'b1;
        AdrSrc    = 1'b1;
      end
      c_s_memwb: begin
        ResultSrc   = c_res_readdata;
        w_reg_write = 1'b1;
      end
      c_s_memwrite: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        AdrSrc      = 1'b1;
      end
      c_s_execr: begin
        ALUSrcA = c_srca_rd1;
        ALUSrcB = c_srcb_rd2;
        ALUOp   = c_aluop_funct;
      end
      c_s_execi: begin
        ALUSrcA = c_srca_rd1;
        ALUSrcB = c_srcb_imm;
        ALUOp   = c_aluop_funct;
      end
      c_s_aluwb: begin
        ResultSrc   = c_res_aluout;
        w_reg_write = 1'b1;
      end
      c_s_beq: begin
        ALUSrcA   = c_srca_rd1;
        ALUSrcB   = c_srcb_rd2;
        ALUOp     = c_aluop_sub;
        ResultSrc = c_res_aluout;
        w_branch  = 1'b1;
      end
      c_s_jal: begin
        ALUSrcA     = c_srca_oldpc;
        ALUSrcB     = c_srcb_four;
        ALUOp       = c_aluop_add;
        ResultSrc   = c_res_aluout;
        w_pc_update = 1'b1;
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  // Side-effecting strobes are held low for the whole time reset is asserted,
  // not just until the state register settles.
  assign MemReq       = RST & w_mem_req;
  assign MemWrite     = RST & w_mem_write;
  assign IRWrite      = RST & w_ir_write;
  assign PCWrite      = RST & (w_pc_update | (w_branch & Zero));
  assign RegWrite     = RST & w_reg_write;
  assign IllegalInstr = RST & w_illegal;

  imm_src_decoder #(
    .OP_W (OP_W)
  ) u_imm_src_decoder (
    .i_op      (Op),
    .o_imm_src (ImmSrc)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_control
// Description : Directed self-checking bench for multicycle_main_control.
//               Each scenario is a table of per-cycle inputs and the full
//               expected output word for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] Op = OP_I;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_main_control #(.OP_W(7), .STATE_W(4)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .IllegalInstr(IllegalInstr)
  );

  always #5 CLK = ~CLK;

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,A,B,ALUOp,Res,Imm,Ill}
  logic [16:0] obs;
  assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, IllegalInstr};

  function automatic logic [16:0] pack(input logic mr, mw, as, ir, pw, rw,
                                       input logic [1:0] a, b, op, rs, imm,
                                       input logic ill);
    return {mr, mw, as, ir, pw, rw, a, b, op, rs, imm, ill};
  endfunction

  // Hand-transcribed expected output words per state
  function automatic logic [16:0] e_reset(input logic [1:0] imm);
    return pack(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, imm, 0);
  endfunction
  function automatic logic [16:0] e_fetch(input logic rdy, input logic [1:0] imm);
    return pack(1,0,0,rdy,rdy,0, 2'b00,2'b10,2'b00,2'b10, imm, 0);
  endfunction
  function automatic logic [16:0] e_decode(input logic [1:0] imm, input logic ill);
    return pack(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, imm, ill);
  endfunction
  function automatic logic [16:0] e_memadr(input logic [1:0] imm);
    return pack(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memread(input logic [1:0] imm);
    return pack(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwb(input logic [1:0] imm);
    return pack(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, imm, 0);
  endfunction
  function automatic logic [16:0] e_memwrite(input logic [1:0] imm);
    return pack(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_execr(input logic [1:0] imm);
    return pack(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_execi(input logic [1:0] imm);
    return pack(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
    return pack(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_beq(input logic z, input logic [1:0] imm);
    return pack(0,0,0,0,z,0, 2'b10,2'b00,2'b01,2'b00, imm, 0);
  endfunction
  function automatic logic [16:0] e_jal(input logic [1:0] imm);
    return pack(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, imm, 0);
  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [16:0] ex;
  } vec_t;

  task automatic test_reset();
    vec_t v[7];
    v[0] = '{1'b0, 1'b1, 1'b0, OP_I, e_reset(2'b00)};
    v[1] = '{1'b0, 1'b1, 1'b0, OP_I, e_reset(2'b00)};
    v[2] = '{1'b0, 1'b1, 1'b0, OP_I, e_reset(2'b00)};
    v[3] = '{1'b1, 1'b1, 1'b0, OP_I, e_fetch(1'b1, 2'b00)};
    v[4] = '{1'b1, 1'b0, 1'b0, OP_I, e_decode(2'b00, 1'b0)};
    v[5] = '{1'b1, 1'b0, 1'b0, OP_I, e_execi(2'b00)};
    v[6] = '{1'b1, 1'b0, 1'b0, OP_I, e_aluwb(2'b00)};
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_lw_stall();
    vec_t v[9];
    v[0] = '{1'b1, 1'b1, 1'b0, OP_LW, e_fetch(1'b1, 2'b00)};
    v[1] = '{1'b1, 1'b1, 1'b0, OP_LW, e_decode(2'b00, 1'b0)}; // MemReady ignored
    v[2] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memadr(2'b00)};
    v[3] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[4] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[5] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[6] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[7] = '{1'b1, 1'b1, 1'b0, OP_LW, e_memread(2'b00)};
    v[8] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memwb(2'b00)};
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL lw cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_sw();
    vec_t v[6];
    v[0] = '{1'b1, 1'b0, 1'b0, OP_SW, e_fetch(1'b0, 2'b01)}; // fetch miss
    v[1] = '{1'b1, 1'b1, 1'b0, OP_SW, e_fetch(1'b1, 2'b01)};
    v[2] = '{1'b1, 1'b0, 1'b0, OP_SW, e_decode(2'b01, 1'b0)};
    v[3] = '{1'b1, 1'b0, 1'b0, OP_SW, e_memadr(2'b01)};
    v[4] = '{1'b1, 1'b1, 1'b0, OP_SW, e_memwrite(2'b01)};
    v[5] = '{1'b1, 1'b0, 1'b0, OP_SW, e_fetch(1'b0, 2'b01)};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_beq();
    vec_t v[6];
    v[0] = '{1'b1, 1'b1, 1'b1, OP_BEQ, e_fetch(1'b1, 2'b10)};
    v[1] = '{1'b1, 1'b0, 1'b1, OP_BEQ, e_decode(2'b10, 1'b0)}; // Zero ignored
    v[2] = '{1'b1, 1'b0, 1'b1, OP_BEQ, e_beq(1'b1, 2'b10)};
    v[3] = '{1'b1, 1'b1, 1'b0, OP_BEQ, e_fetch(1'b1, 2'b10)};
    v[4] = '{1'b1, 1'b0, 1'b0, OP_BEQ, e_decode(2'b10, 1'b0)};
    v[5] = '{1'b1, 1'b0, 1'b0, OP_BEQ, e_beq(1'b0, 2'b10)};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL beq cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_r_i();
    vec_t v[8];
    v[0] = '{1'b1, 1'b1, 1'b0, OP_R, e_fetch(1'b1, 2'b00)};
    v[1] = '{1'b1, 1'b0, 1'b0, OP_R, e_decode(2'b00, 1'b0)};
    v[2] = '{1'b1, 1'b0, 1'b0, OP_R, e_execr(2'b00)};
    v[3] = '{1'b1, 1'b0, 1'b0, OP_R, e_aluwb(2'b00)};
    v[4] = '{1'b1, 1'b1, 1'b0, OP_I, e_fetch(1'b1, 2'b00)};
    v[5] = '{1'b1, 1'b0, 1'b0, OP_I, e_decode(2'b00, 1'b0)};
    v[6] = '{1'b1, 1'b0, 1'b0, OP_I, e_execi(2'b00)};
    v[7] = '{1'b1, 1'b0, 1'b0, OP_I, e_aluwb(2'b00)};
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL r_i cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_jal();
    vec_t v[4];
    v[0] = '{1'b1, 1'b1, 1'b0, OP_JAL, e_fetch(1'b1, 2'b11)};
    v[1] = '{1'b1, 1'b0, 1'b0, OP_JAL, e_decode(2'b11, 1'b0)};
    v[2] = '{1'b1, 1'b0, 1'b0, OP_JAL, e_jal(2'b11)};
    v[3] = '{1'b1, 1'b0, 1'b0, OP_JAL, e_aluwb(2'b11)};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL jal cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v[3];
    v[0] = '{1'b1, 1'b1, 1'b0, OP_BAD, e_fetch(1'b1, 2'b00)};
    v[1] = '{1'b1, 1'b0, 1'b0, OP_BAD, e_decode(2'b00, 1'b1)};
    v[2] = '{1'b1, 1'b0, 1'b0, OP_BAD, e_fetch(1'b0, 2'b00)};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL illegal cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    vec_t v[10];
    v[0] = '{1'b1, 1'b1, 1'b0, OP_LW, e_fetch(1'b1, 2'b00)};
    v[1] = '{1'b1, 1'b0, 1'b0, OP_LW, e_decode(2'b00, 1'b0)};
    v[2] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memadr(2'b00)};
    v[3] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[4] = '{1'b1, 1'b0, 1'b0, OP_LW, e_memread(2'b00)};
    v[5] = '{1'b0, 1'b1, 1'b0, OP_LW, e_reset(2'b00)};
    v[6] = '{1'b0, 1'b0, 1'b0, OP_LW, e_reset(2'b00)};
    v[7] = '{1'b1, 1'b0, 1'b0, OP_LW, e_fetch(1'b0, 2'b00)};
    v[8] = '{1'b1, 1'b1, 1'b0, OP_LW, e_fetch(1'b1, 2'b00)};
    v[9] = '{1'b1, 1'b0, 1'b0, OP_LW, e_decode(2'b00, 1'b0)};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); RST = v[i].rst; MemReady = v[i].rdy; Zero = v[i].z; Op = v[i].op; #1;
      n_checks++;
      if (obs !== v[i].ex) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %05h, expected %05h", i, obs, v[i].ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_stall();
    test_sw();
    test_beq();
    test_r_i();
    test_jal();
    test_illegal();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
